// File: rtl/datamem_xy_rw.sv
// XY-addressed data memory with byte-lane writes, registered read, and a post-reset zero-fill sweep.
// Optional per-lane even parity is enabled by defining DATAMEM_PARITY_EN.
module datamem_xy_rw #(
  parameter int unsigned ADDR_BITS  = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    WriteEnable,
  input  logic [ADDR_BITS-1:0]    Wr_X_addr,
  input  logic [ADDR_BITS-1:0]    Wr_Y_addr,
  input  logic [DATA_WIDTH/8-1:0] Wr_strb,
  input  logic [DATA_WIDTH-1:0]   Data_in,
  input  logic                    ReadEnable,
  input  logic [ADDR_BITS-1:0]    Rd_X_addr,
  input  logic [ADDR_BITS-1:0]    Rd_Y_addr,
  output logic [DATA_WIDTH-1:0]   Data_out,
  output logic                    Rd_valid,
`ifdef DATAMEM_PARITY_EN
  output logic                    Parity_err,
`endif
  output logic                    Init_busy
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = 2 * ADDR_BITS;
  localparam int unsigned DEPTH  = 1 << IDX_W;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  generate
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
      $error("datamem_xy_rw: DATA_WIDTH must be a multiple of 8");
    end
  endgenerate

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [IDX_W-1:0]      r_cnt;
  logic                  r_init_busy;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_run;
  logic [IDX_W-1:0]      w_wr_idx;
  logic [IDX_W-1:0]      w_rd_idx;
  logic                  w_hit;
  logic [DATA_WIDTH-1:0] w_rd_word;

  assign w_run    = (r_state == ST_RUN);
  assign w_wr_idx = {Wr_X_addr, Wr_Y_addr};
  assign w_rd_idx = {Rd_X_addr, Rd_Y_addr};
  assign w_hit    = WriteEnable && (w_wr_idx == w_rd_idx);

  // Next state: sweep ends after the last index has been written.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT) begin
      if (r_cnt == IDX_W'(DEPTH - 1)) begin
        w_state_nxt = ST_RUN;
      end
    end else begin
      w_state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_init_busy <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_init_busy <= (w_state_nxt == ST_INIT);
      if (r_state == ST_INIT) begin
        r_cnt <= r_cnt + IDX_W'(1);
      end
    end
  end

  // Storage: zero-fill during the sweep, strobed lane writes once running.
  always_ff @(posedge Clock) begin
    if (!w_run) begin
      r_mem[r_cnt] <= '0;
    end else if (WriteEnable) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (Wr_strb[k]) begin
          r_mem[w_wr_idx][8*k +: 8] <= Data_in[8*k +: 8];
        end
      end
    end
  end

  // Write-first merge for a same-address read.
  always_comb begin
    w_rd_word = r_mem[w_rd_idx];
    if (w_hit) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (Wr_strb[k]) begin
          w_rd_word[8*k +: 8] = Data_in[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_run && ReadEnable;
      if (w_run && ReadEnable) begin
        r_data_out <= w_rd_word;
      end
    end
  end

  assign Data_out  = r_data_out;
  assign Rd_valid  = r_rd_valid;
  assign Init_busy = r_init_busy;

`ifdef DATAMEM_PARITY_EN
  logic [STRB_W-1:0] r_par [DEPTH];
  logic [STRB_W-1:0] w_par_calc;
  logic              w_par_bad;
  logic              r_parity_err;

  always_ff @(posedge Clock) begin
    if (!w_run) begin
      r_par[r_cnt] <= '0;
    end else if (WriteEnable) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (Wr_strb[k]) begin
          r_par[w_wr_idx][k] <= ^Data_in[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    w_par_calc = '0;
    for (int k = 0; k < STRB_W; k++) begin
      w_par_calc[k] = ^r_mem[w_rd_idx][8*k +: 8];
    end
  end

  // Bypassed data never came from storage, so it is reported clean.
  assign w_par_bad = !w_hit && (|(w_par_calc ^ r_par[w_rd_idx]));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_run && ReadEnable && w_par_bad;
    end
  end

  assign Parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_datamem_xy_rw.sv
// Directed self-checking bench for datamem_xy_rw (ADDR_BITS=4, DATA_WIDTH=32).
// Parity checks are included when DATAMEM_PARITY_EN is defined.
module tb_datamem_xy_rw;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        WriteEnable;
  logic [3:0]  Wr_X_addr, Wr_Y_addr, Rd_X_addr, Rd_Y_addr;
  logic [3:0]  Wr_strb;
  logic [31:0] Data_in;
  logic        ReadEnable;
  logic [31:0] Data_out;
  logic        Rd_valid;
  logic        Init_busy;
`ifdef DATAMEM_PARITY_EN
  logic        Parity_err;
`endif

  int checks = 0;
  int errors = 0;

  datamem_xy_rw #(.ADDR_BITS(4), .DATA_WIDTH(32)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .WriteEnable(WriteEnable),
    .Wr_X_addr  (Wr_X_addr),
    .Wr_Y_addr  (Wr_Y_addr),
    .Wr_strb    (Wr_strb),
    .Data_in    (Data_in),
    .ReadEnable (ReadEnable),
    .Rd_X_addr  (Rd_X_addr),
    .Rd_Y_addr  (Rd_Y_addr),
    .Data_out   (Data_out),
    .Rd_valid   (Rd_valid),
`ifdef DATAMEM_PARITY_EN
    .Parity_err (Parity_err),
`endif
    .Init_busy  (Init_busy)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] x, input logic [3:0] y, input logic [31:0] d,
                    input logic [3:0] s);
    @(negedge Clock);
    WriteEnable = 1'b1; Wr_X_addr = x; Wr_Y_addr = y; Data_in = d; Wr_strb = s;
    @(negedge Clock);
    WriteEnable = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] x, input logic [3:0] y,
                        input logic [31:0] exp);
    @(negedge Clock);
    ReadEnable = 1'b1; Rd_X_addr = x; Rd_Y_addr = y;
    @(negedge Clock);
    ReadEnable = 1'b0;
    chk({tag, "_valid"}, 32'(Rd_valid), 32'd1);
    chk({tag, "_data"}, Data_out, exp);
  endtask

  int n;
  int vcount;

  initial begin
    Reset = 1'b1; WriteEnable = 1'b0; ReadEnable = 1'b0;
    Wr_X_addr = '0; Wr_Y_addr = '0; Rd_X_addr = '0; Rd_Y_addr = '0;
    Wr_strb = '0; Data_in = '0;

    #12;
    chk("rst_data", Data_out, 32'h0);
    chk("rst_valid", 32'(Rd_valid), 32'd0);
    chk("rst_busy", 32'(Init_busy), 32'd1);

    @(negedge Clock);
    Reset = 1'b0;
    n = 0;
    while (Init_busy === 1'b1 && n < 1000) begin
      @(posedge Clock); #1; n++;
    end
    chk("init_cycles", 32'(n), 32'd256);

    rd_chk("rd00", 4'd0, 4'd0, 32'h0);
    rd_chk("rdFF", 4'd15, 4'd15, 32'h0);
    rd_chk("rd79", 4'd7, 4'd9, 32'h0);

    // Write, then partial-lane overwrite, then strb=0 no-op
    wr(4'd3, 4'd5, 32'hDEADBEEF, 4'hF);
    wr(4'd3, 4'd5, 32'h000000AA, 4'b0001);
    rd_chk("rd35", 4'd3, 4'd5, 32'hDEADBEAA);
    @(negedge Clock);
    chk("idle_valid", 32'(Rd_valid), 32'd0);
    chk("idle_hold", Data_out, 32'hDEADBEAA);
    wr(4'd3, 4'd5, 32'hFFFFFFFF, 4'b0000);
    rd_chk("strb0", 4'd3, 4'd5, 32'hDEADBEAA);

    // Same-cycle write-first
    @(negedge Clock);
    WriteEnable = 1'b1; Wr_X_addr = 4'd2; Wr_Y_addr = 4'd2; Data_in = 32'h12345678; Wr_strb = 4'b1100;
    ReadEnable = 1'b1; Rd_X_addr = 4'd2; Rd_Y_addr = 4'd2;
    @(negedge Clock);
    WriteEnable = 1'b0; ReadEnable = 1'b0;
    chk("wf_valid", 32'(Rd_valid), 32'd1);
    chk("wf_data", Data_out, 32'h12340000);
    rd_chk("wf_stored", 4'd2, 4'd2, 32'h12340000);

    // Same-cycle different addresses
    @(negedge Clock);
    WriteEnable = 1'b1; Wr_X_addr = 4'd4; Wr_Y_addr = 4'd4; Data_in = 32'h00000055; Wr_strb = 4'hF;
    ReadEnable = 1'b1; Rd_X_addr = 4'd3; Rd_Y_addr = 4'd5;
    @(negedge Clock);
    WriteEnable = 1'b0; ReadEnable = 1'b0;
    chk("diff_data", Data_out, 32'hDEADBEAA);
    rd_chk("rd44", 4'd4, 4'd4, 32'h00000055);

    // Back-to-back reads
    for (int i = 1; i <= 4; i++) wr(4'd0, 4'(i), 32'(i), 4'hF);
    @(negedge Clock);
    ReadEnable = 1'b1; Rd_X_addr = 4'd0; Rd_Y_addr = 4'd1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge Clock);
      if (i < 4) Rd_Y_addr = 4'(i + 1);
      else ReadEnable = 1'b0;
      chk("b2b_valid", 32'(Rd_valid), 32'd1);
      chk("b2b_data", Data_out, 32'(i));
    end
    @(negedge Clock);
    chk("b2b_end_valid", 32'(Rd_valid), 32'd0);
    chk("b2b_end_hold", Data_out, 32'd4);

    // Reset mid-sweep
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    repeat (100) @(posedge Clock);
    #1;
    chk("sweep100_busy", 32'(Init_busy), 32'd1);
    Reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(Init_busy), 32'd1);
    chk("mid_rst_data", Data_out, 32'h0);
    @(negedge Clock);
    Reset = 1'b0;
    WriteEnable = 1'b1; Wr_X_addr = 4'd0; Wr_Y_addr = 4'd0; Data_in = 32'hFFFFFFFF; Wr_strb = 4'hF;
    ReadEnable = 1'b1; Rd_X_addr = 4'd3; Rd_Y_addr = 4'd5;
    n = 0; vcount = 0;
    while (Init_busy === 1'b1 && n < 1000) begin
      @(posedge Clock); #1; n++;
      if (Rd_valid !== 1'b0) vcount++;
    end
    WriteEnable = 1'b0; ReadEnable = 1'b0;
    chk("resweep_cycles", 32'(n), 32'd256);
    chk("sweep_no_valid", 32'(vcount), 32'd0);
    rd_chk("post_rd00", 4'd0, 4'd0, 32'h0);
    rd_chk("post_rd35", 4'd3, 4'd5, 32'h0);

`ifdef DATAMEM_PARITY_EN
    wr(4'd6, 4'd6, 32'h01020304, 4'hF);
    wr(4'd6, 4'd7, 32'h00000000, 4'hF);
    @(negedge Clock);
    dut.r_par[8'h66][1] = ~dut.r_par[8'h66][1];
    rd_chk("par_bad", 4'd6, 4'd6, 32'h01020304);
    chk("par_bad_err", 32'(Parity_err), 32'd1);
    rd_chk("par_ok", 4'd6, 4'd7, 32'h0);
    chk("par_ok_err", 32'(Parity_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
